cross_channel_diff_scan: RTL and testbench
==========================================

// Module: cross_channel_diff_scan
// PURPOSE
//  Parametrised successor to the BGR flag comparator. Compares each pixel's per-pixel prediction
//  flag in the reference plane against NUM_CH other planes over one tile. Records up to MAX_DIFF
//  differing positions and flags per plane, and reports whether each plane is "similar".
//  Sits between the per-plane flag generators and the bitstream packer.
//  Adds to the previous block: valid/ready handshakes, early termination, and pixel 0 included in the scan.
// PARAMETERS
//  TILE_SIZE  8  tile edge in pixels; N = TILE_SIZE*TILE_SIZE pixels per tile
//  FLAG_W     3  bits per pixel flag
//  NUM_CH     2  number of compared planes (G, R by default)
//  MAX_DIFF   7  max recorded differences per plane; one more difference marks the plane dissimilar
//  Derived: POS_W = clog2(N), CNT_W = clog2(MAX_DIFF+1)
// PORTS
//  clk        in   1                        clock, rising edge
//  rst_n      in   1                        asynchronous, active-low reset
//  i_valid    in   1                        tile flags present
//  i_ready    out  1                        block can accept a tile (high only in IDLE)
//  ref_flag   in   N*FLAG_W                 reference-plane flags; pixel k at [k*FLAG_W +: FLAG_W]
//  cmp_flag   in   NUM_CH*N*FLAG_W          plane c, pixel k at [(c*N+k)*FLAG_W +: FLAG_W]
//  o_valid    out  1                        result valid; held until accepted
//  o_ready    in   1                        downstream accepts result
//  diff_pos   out  NUM_CH*MAX_DIFF*POS_W    plane c, slot s at [(c*MAX_DIFF+s)*POS_W +: POS_W]
//  diff_flag  out  NUM_CH*MAX_DIFF*FLAG_W   compared-plane flag at that position, same indexing
//  diff_num   out  NUM_CH*CNT_W             recorded differences per plane, 0..MAX_DIFF
//  similar    out  NUM_CH                   1 = plane differs in at most MAX_DIFF pixels
//  busy       out  1                        state != IDLE
// BEHAVIOUR
//  Reset (async): state IDLE; all outputs and internal records 0, except i_ready = 1 once in IDLE.
//  A reset during SCAN or DONE aborts the tile. No output is produced for it.
//  FSM states: IDLE, SCAN, DONE.
//   IDLE: i_ready = 1. On i_valid, latch ref_flag and cmp_flag, clear all records, set idx = 0,
//     clear the overflow bits, and go to SCAN.
//   SCAN: at each edge compare pixel idx for every plane that has not overflowed.
//     - A difference with count < MAX_DIFF stores pos = idx and flag = cmp flag in slot [count],
//       then increments count.
//     - A difference with count == MAX_DIFF sets ovf[c]. Slots stay frozen and count stays MAX_DIFF.
//     - Overflowed planes are no longer compared.
//     Exit to DONE when idx == N-1, or when every plane has ovf set (early termination).
//   DONE: o_valid = 1. All outputs stay stable until o_valid && o_ready, then go to IDLE.
//     A new tile is accepted no earlier than the cycle after the handshake.
//  Input handshake: i_valid is ignored while i_ready = 0. Tile data need only be valid in the accept cycle.
//  Latency: acceptance edge E0; pixel k is evaluated on edge E0+k+1.
//   - Full scan: o_valid rises after edge E0+N (N = 64 gives 64 cycles).
//   - Early termination: o_valid rises after the edge that sets the last ovf bit.
//  Output values:
//   - similar[c] = !ovf[c]; diff_num[c] = count[c]. An overflowed plane reports diff_num = MAX_DIFF, similar = 0.
//   - Unused slots read 0. A position is an absolute pixel index in raster order.
//  Widths: compare on exactly FLAG_W bits. The counter never wraps and saturates at MAX_DIFF.
//  Outputs are registered and reflect the working records. Consumers sample them only while o_valid = 1.
// STRUCTURE
//  Shared package cdiff_pkg: state enum {IDLE, SCAN, DONE}, and clog2-based POS_W/CNT_W helper functions.
//  Sub-module diff_slot_recorder, instantiated NUM_CH times. Per plane it holds:
//   - count, ovf, and the slot arrays;
//   - inputs: clear, en, mismatch, idx, flag.
//  The top level holds the FSM, the idx counter, the latched tile flags, and the per-pixel
//  flag muxing. Early termination is the AND of all recorder ovf bits.
// TESTING
//  1. Identical planes -> o_valid exactly 64 cycles after accept; similar = 2'b11, diff_num = 0, slots 0.
//  2. Plane0 differs at pixels 0, 5, 63 with flags 1, 2, 7 -> diff_num0 = 3, pos = {0, 5, 63},
//     flag = {1, 2, 7}, similar0 = 1. Plane1 is clean.
//  3. Plane0 has exactly 7 differences -> similar0 = 1, diff_num0 = 7.
//     Plane1 has 8 differences -> similar1 = 0, diff_num1 = 7, and slots hold the first 7 only.
//  4. Both planes differ at every pixel -> early termination: o_valid after E0+8 (pixel 7);
//     similar = 0, positions 0..6 in both planes.
//  5. Hold o_ready low 10 cycles in DONE while pulsing i_valid with a new tile -> outputs stable,
//     i_ready = 0, tile ignored. Raise o_ready -> IDLE next cycle, then the next tile scans correctly.
//  6. Assert rst_n low at pixel 30 of a scan -> all outputs 0, no o_valid.
//     After release i_ready = 1, and a fresh tile gives correct results.

Source files
------------

// File: rtl/cdiff_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cdiff_pkg : shared state encoding and width helpers for the diff scanner
// Revision  : 1.0
// ---------------------------------------------------------------------------
package cdiff_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int calc_pos_w(input int tile_size);
    return (tile_size * tile_size > 1) ? $clog2(tile_size * tile_size) : 1;
  endfunction

  function automatic int calc_cnt_w(input int max_diff);
    return (max_diff > 0) ? $clog2(max_diff + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/diff_slot_recorder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// diff_slot_recorder : per-plane saturating record of differing positions
// Revision           : 1.0
// ---------------------------------------------------------------------------
module diff_slot_recorder #(
  parameter int POS_W    = 6,
  parameter int FLAG_W   = 3,
  parameter int MAX_DIFF = 7,
  parameter int CNT_W    = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_i,
  input  logic                         en_i,
  input  logic                         mismatch_i,
  input  logic [POS_W-1:0]             idx_i,
  input  logic [FLAG_W-1:0]            flag_i,
  output logic [MAX_DIFF*POS_W-1:0]    pos_o,
  output logic [MAX_DIFF*FLAG_W-1:0]   flag_o,
  output logic [CNT_W-1:0]             count_o,
  output logic                         similar_o,
  output logic                         ovf_next_o
);

  logic [POS_W-1:0]  pos_q  [MAX_DIFF];
  logic [FLAG_W-1:0] flag_q [MAX_DIFF];
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;
  logic              similar_q;
  logic              w_hit;
  logic              w_full;

  assign w_hit      = en_i & ~ovf_q & mismatch_i;
  assign w_full     = (count_q == CNT_W'(MAX_DIFF));
  assign ovf_next_o = ovf_q | (w_hit & w_full);

  // similar is held at 0 out of reset so every output reads 0 before the first tile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      ovf_q     <= 1'b0;
      similar_q <= 1'b0;
      for (int s = 0; s < MAX_DIFF; s++) begin
        pos_q[s]  <= '0;
        flag_q[s] <= '0;
      end
    end else if (clear_i) begin
      count_q   <= '0;
      ovf_q     <= 1'b0;
      similar_q <= 1'b1;
      for (int s = 0; s < MAX_DIFF; s++) begin
        pos_q[s]  <= '0;
        flag_q[s] <= '0;
      end
    end else if (w_hit) begin
      if (w_full) begin
        ovf_q     <= 1'b1;
        similar_q <= 1'b0;
      end else begin
        count_q <= count_q + CNT_W'(1);
        for (int s = 0; s < MAX_DIFF; s++) begin
          if (count_q == CNT_W'(s)) begin
            pos_q[s]  <= idx_i;
            flag_q[s] <= flag_i;
          end
        end
      end
    end
  end

  for (genvar s = 0; s < MAX_DIFF; s++) begin : g_slot
    assign pos_o[s*POS_W +: POS_W]    = pos_q[s];
    assign flag_o[s*FLAG_W +: FLAG_W] = flag_q[s];
  end

  assign count_o   = count_q;
  assign similar_o = similar_q;

endmodule
`default_nettype wire

// File: rtl/cross_channel_diff_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cross_channel_diff_scan : compares reference-plane pixel flags against
// NUM_CH planes over one tile, recording up to MAX_DIFF differences each.
// Revision                : 1.0
// ---------------------------------------------------------------------------
module cross_channel_diff_scan
  import cdiff_pkg::*;
#(
  parameter int TILE_SIZE = 8,
  parameter int FLAG_W    = 3,
  parameter int NUM_CH    = 2,
  parameter int MAX_DIFF  = 7,
  localparam int N        = TILE_SIZE * TILE_SIZE,
  localparam int POS_W    = calc_pos_w(TILE_SIZE),
  localparam int CNT_W    = calc_cnt_w(MAX_DIFF)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_valid,
  output logic                                i_ready,
  input  logic [N*FLAG_W-1:0]                 ref_flag,
  input  logic [NUM_CH*N*FLAG_W-1:0]          cmp_flag,
  output logic                                o_valid,
  input  logic                                o_ready,
  output logic [NUM_CH*MAX_DIFF*POS_W-1:0]    diff_pos,
  output logic [NUM_CH*MAX_DIFF*FLAG_W-1:0]   diff_flag,
  output logic [NUM_CH*CNT_W-1:0]             diff_num,
  output logic [NUM_CH-1:0]                   similar,
  output logic                                busy
);

  state_t            state_q;
  logic [POS_W-1:0]  idx_q;
  logic [FLAG_W-1:0] ref_q [N];
  logic [FLAG_W-1:0] cmp_q [NUM_CH][N];
  logic              i_ready_q;
  logic              o_valid_q;
  logic              busy_q;

  logic              w_accept;
  logic              w_scan;
  logic              w_all_ovf;
  logic [FLAG_W-1:0] w_ref_pix;
  logic [FLAG_W-1:0] w_cmp_pix [NUM_CH];
  logic [NUM_CH-1:0] w_mismatch;
  logic [NUM_CH-1:0] w_ovf_next;

  assign w_accept  = (state_q == S_IDLE) & i_valid;
  assign w_scan    = (state_q == S_SCAN);
  assign w_all_ovf = &w_ovf_next;
  assign w_ref_pix = ref_q[idx_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      i_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      for (int k = 0; k < N; k++) begin
        ref_q[k] <= '0;
        for (int c = 0; c < NUM_CH; c++) cmp_q[c][k] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            for (int k = 0; k < N; k++) begin
              ref_q[k] <= ref_flag[k*FLAG_W +: FLAG_W];
              for (int c = 0; c < NUM_CH; c++)
                cmp_q[c][k] <= cmp_flag[(c*N+k)*FLAG_W +: FLAG_W];
            end
            idx_q     <= '0;
            state_q   <= S_SCAN;
            i_ready_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_SCAN: begin
          // early exit uses next-cycle overflow so the edge that saturates the last plane ends the scan
          if (idx_q == POS_W'(N-1) || w_all_ovf) begin
            state_q   <= S_DONE;
            o_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + POS_W'(1);
          end
        end
        S_DONE: begin
          if (o_ready) begin
            state_q   <= S_IDLE;
            o_valid_q <= 1'b0;
            i_ready_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          o_valid_q <= 1'b0;
          i_ready_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_cmp_pix[c]  = cmp_q[c][idx_q];
    assign w_mismatch[c] = (w_cmp_pix[c] != w_ref_pix);

    diff_slot_recorder #(
      .POS_W    (POS_W),
      .FLAG_W   (FLAG_W),
      .MAX_DIFF (MAX_DIFF),
      .CNT_W    (CNT_W)
    ) u_rec (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (w_accept),
      .en_i       (w_scan),
      .mismatch_i (w_mismatch[c]),
      .idx_i      (idx_q),
      .flag_i     (w_cmp_pix[c]),
      .pos_o      (diff_pos[c*MAX_DIFF*POS_W +: MAX_DIFF*POS_W]),
      .flag_o     (diff_flag[c*MAX_DIFF*FLAG_W +: MAX_DIFF*FLAG_W]),
      .count_o    (diff_num[c*CNT_W +: CNT_W]),
      .similar_o  (similar[c]),
      .ovf_next_o (w_ovf_next[c])
    );
  end

  assign i_ready = i_ready_q;
  assign o_valid = o_valid_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cross_channel_diff_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cross_channel_diff_scan : directed table-driven bench for the diff scanner
// Revision                   : 1.0
// ---------------------------------------------------------------------------
module tb_cross_channel_diff_scan;

  localparam int TILE_SIZE = 8;
  localparam int FLAG_W    = 3;
  localparam int NUM_CH    = 2;
  localparam int MAX_DIFF  = 7;
  localparam int N         = 64;
  localparam int POS_W     = 6;
  localparam int CNT_W     = 3;
  localparam int NV        = 5;

  logic                              clk;
  logic                              rst_n;
  logic                              i_valid;
  logic                              i_ready;
  logic [N*FLAG_W-1:0]               ref_flag;
  logic [NUM_CH*N*FLAG_W-1:0]        cmp_flag;
  logic                              o_valid;
  logic                              o_ready;
  logic [NUM_CH*MAX_DIFF*POS_W-1:0]  diff_pos;
  logic [NUM_CH*MAX_DIFF*FLAG_W-1:0] diff_flag;
  logic [NUM_CH*CNT_W-1:0]           diff_num;
  logic [NUM_CH-1:0]                 similar;
  logic                              busy;

  typedef struct {
    logic [N*FLAG_W-1:0]               ref_v;
    logic [NUM_CH*N*FLAG_W-1:0]        cmp_v;
    int                                lat;
    logic [NUM_CH-1:0]                 sim;
    logic [NUM_CH*CNT_W-1:0]           num;
    logic [NUM_CH*MAX_DIFF*POS_W-1:0]  pos;
    logic [NUM_CH*MAX_DIFF*FLAG_W-1:0] flg;
  } vec_t;

  vec_t vecs [NV];
  vec_t cur;
  int   checks;
  int   errors;

  cross_channel_diff_scan #(
    .TILE_SIZE (TILE_SIZE),
    .FLAG_W    (FLAG_W),
    .NUM_CH    (NUM_CH),
    .MAX_DIFF  (MAX_DIFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .ref_flag  (ref_flag),
    .cmp_flag  (cmp_flag),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .diff_pos  (diff_pos),
    .diff_flag (diff_flag),
    .diff_num  (diff_num),
    .similar   (similar),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_cur();
    cur.ref_v = '0;
    cur.cmp_v = '0;
    cur.lat   = N;
    cur.sim   = '1;
    cur.num   = '0;
    cur.pos   = '0;
    cur.flg   = '0;
  endtask

  task automatic set_ref(input int k, input int f);
    cur.ref_v[k*FLAG_W +: FLAG_W] = FLAG_W'(f);
  endtask

  task automatic set_cmp(input int c, input int k, input int f);
    cur.cmp_v[(c*N+k)*FLAG_W +: FLAG_W] = FLAG_W'(f);
  endtask

  task automatic exp_slot(input int c, input int s, input int p, input int f);
    cur.pos[(c*MAX_DIFF+s)*POS_W +: POS_W]  = POS_W'(p);
    cur.flg[(c*MAX_DIFF+s)*FLAG_W +: FLAG_W] = FLAG_W'(f);
  endtask

  task automatic exp_num(input int c, input int n);
    cur.num[c*CNT_W +: CNT_W] = CNT_W'(n);
  endtask

  // accept a tile, then corrupt the inputs to prove only the accept-cycle data matters
  task automatic start_and_wait(input int i, output int cyc);
    @(negedge clk);
    ref_flag = vecs[i].ref_v;
    cmp_flag = vecs[i].cmp_v;
    i_valid  = 1'b1;
    check($sformatf("v%0d_iready", i), {127'd0, i_ready}, 128'd1);
    @(posedge clk);
    #1;
    i_valid  = 1'b0;
    ref_flag = ~vecs[i].ref_v;
    cmp_flag = ~vecs[i].cmp_v;
    cyc = 0;
    while (!o_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_results(input int i, input int cyc);
    check($sformatf("v%0d_latency", i), 128'(cyc), 128'(vecs[i].lat));
    check($sformatf("v%0d_similar", i), 128'(similar), 128'(vecs[i].sim));
    check($sformatf("v%0d_diff_num", i), 128'(diff_num), 128'(vecs[i].num));
    check($sformatf("v%0d_diff_pos", i), 128'(diff_pos), 128'(vecs[i].pos));
    check($sformatf("v%0d_diff_flag", i), 128'(diff_flag), 128'(vecs[i].flg));
  endtask

  task automatic handshake(input int i);
    @(negedge clk);
    o_ready = 1'b1;
    @(posedge clk);
    #1;
    o_ready = 1'b0;
    check($sformatf("v%0d_post_iready", i), {126'd0, i_ready, o_valid}, 128'd2);
  endtask

  task automatic run_vec(input int i);
    int cyc;
    start_and_wait(i, cyc);
    check_results(i, cyc);
    handshake(i);
  endtask

  initial begin
    int cyc;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    i_valid  = 1'b0;
    o_ready  = 1'b0;
    ref_flag = '0;
    cmp_flag = '0;

    // v0: identical planes, non-trivial reference pattern
    clr_cur();
    for (int k = 0; k < N; k++) begin
      set_ref(k, k % 8);
      set_cmp(0, k, k % 8);
      set_cmp(1, k, k % 8);
    end
    vecs[0] = cur;

    // v1: plane0 differs at 0, 5, 63
    clr_cur();
    set_cmp(0, 0, 1); set_cmp(0, 5, 2); set_cmp(0, 63, 7);
    exp_num(0, 3);
    exp_slot(0, 0, 0, 1); exp_slot(0, 1, 5, 2); exp_slot(0, 2, 63, 7);
    vecs[1] = cur;

    // v2: plane0 exactly 7 differences, plane1 8 differences
    clr_cur();
    for (int k = 1; k <= 7; k++) begin
      set_cmp(0, k, 4);
      exp_slot(0, k - 1, k, 4);
    end
    for (int s = 0; s < 7; s++) begin
      set_cmp(1, 8 * (s + 1), s + 1);
      exp_slot(1, s, 8 * (s + 1), s + 1);
    end
    set_cmp(1, 60, 1);
    exp_num(0, 7); exp_num(1, 7);
    cur.sim = 2'b01;
    vecs[2] = cur;

    // v3: every pixel differs in both planes -> early exit on pixel 7
    clr_cur();
    for (int k = 0; k < N; k++) begin
      set_cmp(0, k, 5);
      set_cmp(1, k, (k % 7) + 1);
    end
    for (int s = 0; s < 7; s++) begin
      exp_slot(0, s, s, 5);
      exp_slot(1, s, s, s + 1);
    end
    exp_num(0, 7); exp_num(1, 7);
    cur.sim = 2'b00;
    cur.lat = 8;
    vecs[3] = cur;

    // v4: plane0 overflows, plane1 clean except last pixel -> no early exit
    clr_cur();
    for (int k = 0; k < 8; k++) set_cmp(0, k, 2);
    for (int s = 0; s < 7; s++) exp_slot(0, s, s, 2);
    set_cmp(1, 63, 6);
    exp_slot(1, 0, 63, 6);
    exp_num(0, 7); exp_num(1, 1);
    cur.sim = 2'b10;
    vecs[4] = cur;

    #12;
    check("reset_outputs", {o_valid, busy, similar, diff_num, diff_pos[31:0]}, '0);
    check("reset_iready", {127'd0, i_ready}, 128'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i);

    // DONE held with o_ready low while a new tile is offered
    start_and_wait(1, cyc);
    check_results(1, cyc);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      i_valid  = (t % 2 == 0);
      ref_flag = vecs[3].ref_v;
      cmp_flag = vecs[3].cmp_v;
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_ctrl", t), {125'd0, o_valid, i_ready, busy}, 128'b101);
      check($sformatf("hold%0d_data", t), {diff_num, similar, diff_pos[63:0]},
            {vecs[1].num, vecs[1].sim, vecs[1].pos[63:0]});
    end
    i_valid = 1'b0;
    handshake(1);
    run_vec(2);

    // reset in the middle of a scan
    @(negedge clk);
    ref_flag = vecs[2].ref_v;
    cmp_flag = vecs[2].cmp_v;
    i_valid  = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {o_valid, busy, similar, diff_num, diff_pos[63:0]}, '0);
    check("abort_flags", 128'(diff_flag), '0);
    check("abort_iready", {127'd0, i_ready}, 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("abort_no_valid", {127'd0, o_valid}, '0);
    end
    run_vec(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
